// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game judging slice: lane layout, FSM encoding,
// scoring limits and the saturating score adder.
package rhythm_pkg;

  localparam int LANES       = 4;
  localparam int LANE_RED    = 0;
  localparam int LANE_GREEN  = 1;
  localparam int LANE_BLUE   = 2;
  localparam int LANE_YELLOW = 3;

  localparam logic [7:0]  COMBO_BONUS_CAP = 8'd15;
  localparam logic [7:0]  COMBO_MAX       = 8'd255;
  localparam logic [15:0] SCORE_MAX       = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_WINDOW = 2'd2,
    ST_DONE   = 2'd3
  } judge_state_t;

  // Score plus row points, clamped at SCORE_MAX.
  function automatic logic [15:0] sat_add_score(input logic [15:0] score,
                                                input logic [17:0] pts);
    logic [18:0] sum;
    sum = {3'b000, score} + {1'b0, pts};
    return (sum > {3'b000, SCORE_MAX}) ? SCORE_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// One lane button: 2-flop synchroniser into the pixel clock, then a rising-edge
// detector that yields a single-cycle press.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a real three-stage shift; blocking
      // ones would collapse the chain into a single flop within one evaluation.
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/hit_judge.sv
// Judges lane presses against the scrolling note row: hit mask, score, combo, miss.
// Define HIT_JUDGE_PERFECT_EN to build the perfect band (double points, perfect pulse).
module hit_judge
  import rhythm_pkg::*;
#(
  parameter logic [7:0]  TARGET_Y = 8'd40,
  parameter logic [7:0]  WINDOW   = 8'd6,
  parameter logic [15:0] BASE_PTS = 16'd10
`ifdef HIT_JUDGE_PERFECT_EN
  , parameter logic [7:0] PERFECT_WIN = 8'd1
`endif
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic              row_valid,
  input  logic [LANES-1:0]  row_cmd,
  input  logic [7:0]        row_y,
  input  logic [LANES-1:0]  btn,
  output logic              row_done,
  output logic [LANES-1:0]  hit_mask,
  output logic [15:0]       score,
  output logic [7:0]        combo,
  output logic              miss,
  output logic              perfect
);

  logic [LANES-1:0] w_press;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    btn_sync_edge u_sync (
      .i_clk   (CLOCK_25),
      .i_rst   (reset),
      .i_btn   (btn[g]),
      .o_press (w_press[g])
    );
  end

  judge_state_t     r_state,    w_state_nx;
  logic [LANES-1:0] r_pending,  w_pending_nx;
  logic [LANES-1:0] r_hit_mask, w_hit_mask_nx;
  logic [15:0]      r_score,    w_score_nx;
  logic [7:0]       r_combo,    w_combo_nx;
  logic             r_miss,     w_miss_nx;

  logic             w_in_reach;
  logic             w_passed;
  logic [LANES-1:0] w_hits;
  logic [LANES-1:0] w_left;
  logic             w_stray;
  logic [7:0]       w_combo_base;
  logic [7:0]       w_bonus;
  logic [17:0]      w_pts;
  logic [17:0]      w_row_pts;

  assign w_in_reach = (row_y <= TARGET_Y + WINDOW);
  // Above the window while in WINDOW can only mean row_y wrapped past zero.
  assign w_passed   = (row_y < TARGET_Y - WINDOW) || (row_y > TARGET_Y + WINDOW);

  assign w_hits  = w_press & r_pending;
  assign w_left  = r_pending & ~w_press;
  assign w_stray = |(w_press & ~r_pending);

  // A stray press in the same cycle as the completing hit breaks the streak first.
  assign w_combo_base = w_stray ? 8'd0 : r_combo;
  assign w_bonus      = (w_combo_base > COMBO_BONUS_CAP) ? COMBO_BONUS_CAP : w_combo_base;
  assign w_pts        = {2'b00, BASE_PTS} + {10'd0, w_bonus};

`ifdef HIT_JUDGE_PERFECT_EN
  logic       r_all_perf, w_all_perf_nx;
  logic       r_perfect,  w_perfect_nx;
  logic [7:0] w_dist;
  logic       w_hit_perf;
  logic       w_row_perf;

  assign w_dist     = (row_y >= TARGET_Y) ? (row_y - TARGET_Y) : (TARGET_Y - row_y);
  assign w_hit_perf = (w_dist <= PERFECT_WIN);
  assign w_row_perf = r_all_perf && w_hit_perf;
  assign w_row_pts  = w_row_perf ? {w_pts[16:0], 1'b0} : w_pts;
  assign perfect    = r_perfect;
`else
  assign w_row_pts  = w_pts;
  assign perfect    = 1'b0;
`endif

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    w_state_nx    = r_state;
    w_pending_nx  = r_pending;
    w_hit_mask_nx = r_hit_mask;
    w_score_nx    = r_score;
    w_combo_nx    = r_combo;
    w_miss_nx     = 1'b0;
`ifdef HIT_JUDGE_PERFECT_EN
    w_all_perf_nx = r_all_perf;
    w_perfect_nx  = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (row_valid) begin
          w_pending_nx  = row_cmd;
          w_hit_mask_nx = '0;
`ifdef HIT_JUDGE_PERFECT_EN
          w_all_perf_nx = 1'b1;
`endif
          w_state_nx    = (row_cmd == '0) ? ST_DONE : ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!row_valid)      w_state_nx = ST_IDLE;
        else if (w_in_reach) w_state_nx = ST_WINDOW;
      end
      ST_WINDOW: begin
        if (!row_valid) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_pending_nx  = w_left;
          w_hit_mask_nx = r_hit_mask | w_hits;
          if (w_stray) w_combo_nx = 8'd0;
`ifdef HIT_JUDGE_PERFECT_EN
          if ((w_hits != '0) && !w_hit_perf) w_all_perf_nx = 1'b0;
`endif
          // The press is judged before the pass test, so a last-moment hit still counts.
          if (w_left == '0) begin
            w_score_nx = sat_add_score(r_score, w_row_pts);
            w_combo_nx = (w_combo_base == COMBO_MAX) ? COMBO_MAX : w_combo_base + 8'd1;
`ifdef HIT_JUDGE_PERFECT_EN
            w_perfect_nx = w_row_perf;
`endif
            w_state_nx = ST_DONE;
          end else if (w_passed) begin
            w_miss_nx  = 1'b1;
            w_combo_nx = 8'd0;
            w_state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!row_valid) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_hit_mask <= '0;
      r_score    <= '0;
      r_combo    <= '0;
      r_miss     <= 1'b0;
`ifdef HIT_JUDGE_PERFECT_EN
      r_all_perf <= 1'b0;
      r_perfect  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_pending  <= w_pending_nx;
      r_hit_mask <= w_hit_mask_nx;
      r_score    <= w_score_nx;
      r_combo    <= w_combo_nx;
      r_miss     <= w_miss_nx;
`ifdef HIT_JUDGE_PERFECT_EN
      r_all_perf <= w_all_perf_nx;
      r_perfect  <= w_perfect_nx;
`endif
    end
  end

  assign row_done = (r_state == ST_DONE);
  assign hit_mask = r_hit_mask;
  assign score    = r_score;
  assign combo    = r_combo;
  assign miss     = r_miss;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: expected row results are queued when a row is driven
// and compared when the DUT reports row_done.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       row_valid;
  logic [3:0] row_cmd;
  logic [7:0] row_y;
  logic [3:0] btn;
  logic       row_done;
  logic [3:0] hit_mask;
  logic [15:0] score;
  logic [7:0] combo;
  logic       miss;
  logic       perfect;

  hit_judge dut (
    .CLOCK_25  (clk),
    .reset     (rst),
    .row_valid (row_valid),
    .row_cmd   (row_cmd),
    .row_y     (row_y),
    .btn       (btn),
    .row_done  (row_done),
    .hit_mask  (hit_mask),
    .score     (score),
    .combo     (combo),
    .miss      (miss),
    .perfect   (perfect)
  );

  always #20 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [3:0]  mask;
    logic [15:0] score;
    logic [7:0]  combo;
  } exp_t;

  exp_t sb[$];

  int unsigned m_score;
  int unsigned m_combo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Independent scoring model for one fully hit row.
  task automatic model_hit(input bit perf);
    int unsigned pts;
    pts = 10 + ((m_combo > 15) ? 15 : m_combo);
    if (perf) pts = pts * 2;
    m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
    m_combo = (m_combo == 255) ? 255 : m_combo + 1;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] mask);
    exp_t e;
    e.tag   = tag;
    e.mask  = mask;
    e.score = m_score[15:0];
    e.combo = m_combo[7:0];
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    check("sb_has_entry", (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_row_done"}, row_done, 1);
      check({e.tag, "_hit_mask"}, hit_mask, e.mask);
      check({e.tag, "_score"}, score, e.score);
      check({e.tag, "_combo"}, combo, e.combo);
    end
  endtask

  // One cycle per Y value; a lane button rises two rows early so the judge sees it at ya.
  task automatic scroll(input int y0, input int y1, input int la, input int ya,
                        input int lb, input int yb, output int miss_n, output int perf_n);
    miss_n = 0;
    perf_n = 0;
    for (int y = y0; y >= y1; y--) begin
      row_y = 8'(y);
      if (la >= 0 && y == ya + 2) btn[la] = 1'b1;
      if (la >= 0 && y == ya - 1) btn[la] = 1'b0;
      if (lb >= 0 && y == yb + 2) btn[lb] = 1'b1;
      if (lb >= 0 && y == yb - 1) btn[lb] = 1'b0;
      @(negedge clk);
      miss_n += int'(miss);
      perf_n += int'(perfect);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      miss_n += int'(miss);
      perf_n += int'(perfect);
      @(posedge clk);
      #1;
    end
    btn = 4'b0000;
  endtask

  task automatic end_row();
    row_valid = 1'b0;
    tick(1);
    check("row_done_cleared", row_done, 0);
    tick(1);
  endtask

  task automatic fast_row();
    int waited;
    model_hit(1'b0);
    push_exp("fast", 4'b0001);
    row_cmd   = 4'b0001;
    row_y     = 8'd44;
    row_valid = 1'b1;
    btn[0]    = 1'b1;
    waited    = 0;
    while (!row_done && waited < 12) begin
      tick(1);
      waited++;
    end
    pop_compare();
    row_valid = 1'b0;
    btn       = 4'b0000;
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_score = 0;
    m_combo = 0;
    tick(1);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mc, pc, rows;
    rst = 1'b1; row_valid = 1'b0; row_cmd = 4'b0000; row_y = 8'd0; btn = 4'b0000;
    m_score = 0; m_combo = 0;
    tick(2);
    check("rst_score", score, 0);
    check("rst_combo", combo, 0);
    check("rst_hit_mask", hit_mask, 0);
    check("rst_row_done", row_done, 0);
    check("rst_miss", miss, 0);
    check("rst_perfect", perfect, 0);
    rst = 1'b0;
    tick(1);

    // Unhit row scrolls out of the window.
    m_combo = 0;
    push_exp("miss_row", 4'b0000);
    row_cmd = 4'b0010; row_valid = 1'b1;
    scroll(50, 33, -1, 0, -1, 0, mc, pc);
    check("miss_pulse_cycles", mc, 1);
    pop_compare();
    end_row();

    // Two-lane row hit at y=43 and y=38.
    model_hit(1'b0);
    push_exp("two_lane", 4'b0101);
    row_cmd = 4'b0101; row_valid = 1'b1;
    scroll(50, 34, 0, 43, 2, 38, mc, pc);
    check("two_lane_no_miss", mc, 0);
    pop_compare();
    end_row();

    // Empty row goes straight to done with no scoring.
    push_exp("empty_row", 4'b0000);
    row_cmd = 4'b0000; row_valid = 1'b1;
    tick(2);
    pop_compare();
    end_row();

    // Stray press breaks the combo, then the real lane completes the row.
    row_cmd = 4'b0001; row_valid = 1'b1;
    scroll(50, 42, 3, 44, -1, 0, mc, pc);
    m_combo = 0;
    check("stray_combo", combo, m_combo);
    check("stray_not_done", row_done, 0);
    check("stray_no_hit", hit_mask, 0);
    model_hit(1'b0);
    push_exp("after_stray", 4'b0001);
    scroll(41, 34, 0, 38, -1, 0, mc, pc);
    pop_compare();
    end_row();

    // Reset in the middle of a live row.
    row_cmd = 4'b0001; row_valid = 1'b1;
    scroll(50, 44, -1, 0, -1, 0, mc, pc);
    rst = 1'b1;
    tick(1);
    check("midrow_rst_score", score, 0);
    check("midrow_rst_combo", combo, 0);
    check("midrow_rst_hit_mask", hit_mask, 0);
    check("midrow_rst_row_done", row_done, 0);
    row_valid = 1'b0;
    rst = 1'b0;
    m_score = 0; m_combo = 0;
    tick(2);

    // Drive score and combo to their saturation points.
    rows = 0;
    while (m_score < 65520 && rows < 3000) begin
      fast_row();
      rows++;
    end
    check("pre_sat_combo", combo, 255);
    fast_row();
    check("sat_score", score, 16'hFFFF);
    check("sat_combo", combo, 255);
    fast_row();
    check("sat_score_hold", score, 16'hFFFF);

`ifdef HIT_JUDGE_PERFECT_EN
    do_reset();
    model_hit(1'b1);
    push_exp("perfect_row", 4'b1000);
    row_cmd = 4'b1000; row_valid = 1'b1;
    scroll(50, 34, 3, 40, -1, 0, mc, pc);
    check("perfect_pulses", pc, 1);
    pop_compare();
    end_row();
    do_reset();
    model_hit(1'b0);
    push_exp("good_row", 4'b1000);
    row_cmd = 4'b1000; row_valid = 1'b1;
    scroll(50, 34, 3, 44, -1, 0, mc, pc);
    check("good_no_perfect", pc, 0);
    pop_compare();
    end_row();
`else
    do_reset();
    model_hit(1'b0);
    push_exp("flat_row", 4'b1000);
    row_cmd = 4'b1000; row_valid = 1'b1;
    scroll(50, 34, 3, 40, -1, 0, mc, pc);
    check("flat_no_perfect", pc, 0);
    pop_compare();
    end_row();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
